cpu_ctrl_fsm: RTL

Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, decode, execute, memory and writeback around the instruction decoder, regfile and ALU. It drives the single shared memory-bus request port for both instruction and data accesses, and emits all datapath write-enables and mux selects. One instruction is in flight at a time.

---
 rtl/cpu_ctrl_pkg.sv | 45 ++++
 rtl/ctrl_bus_timer.sv | 33 +++
 rtl/cpu_ctrl_fsm.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the RV32I multi-cycle control FSM.
//   state_t      - FSM state encoding (also exported on state_o for debug)
//   OP_*         - major opcode values of the legal RV32I instruction classes
//   PC_SRC_*     - pc_src_o encodings
//   WB_SEL_*     - wb_sel_o encodings
//   is_legal_op  - classifies an opcode as a supported instruction class
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [1:0] PC_SRC_PC4  = 2'd0;  // PC + 4
  localparam logic [1:0] PC_SRC_REL  = 2'd1;  // old_pc + imm
  localparam logic [1:0] PC_SRC_JALR = 2'd2;  // ALU & ~1

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;   // old_pc + 4 (link)

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_bus_timer.sv
// ctrl_bus_timer: bus wait watchdog for cpu_ctrl_fsm.
// Only built when CTRL_BUS_TIMEOUT_EN is defined; otherwise this file is empty.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clr         - restart the count (not waiting, or access acknowledged)
//   tick        - one cycle spent waiting without acknowledge
//   expired     - this waiting cycle is the TIMEOUT_CYCLES-th without ack
`ifdef CTRL_BUS_TIMEOUT_EN
module ctrl_bus_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = 16;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (tick) cnt <= cnt + 1'b1;
  end

  // cnt counts earlier unacked cycles, so the current cycle is number cnt+1.
  assign expired = tick && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb).
// Drives the shared memory-bus request port and all datapath strobes/selects.
// Optional macro CTRL_BUS_TIMEOUT_EN: bus waits longer than TIMEOUT_CYCLES
// trap with bus_err_o; without it bus waits are unbounded and bus_err_o = 0.
// Ports:
//   clk, reset        - clock, async active-low reset
//   opcode            - IR opcode field (stable from DECODE until next fetch)
//   branch_cond_i     - ALU compare result, taken when high
//   mem_ack_i         - bus acknowledge
//   mem_req_o/we/addr_sel - bus request, write, address select (0 PC, 1 ALU)
//   ir_we_o, pc_we_o, pc_src_o, pc_rst_o - IR / PC control
//   rf_we_o, wb_sel_o - regfile write strobe and writeback source
//   illegal_o, bus_err_o - sticky trap causes
//   state_o           - current state for debug
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_ADDR        = 32'h8000_0000,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_cond_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_addr_sel_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       pc_rst_o,
  output logic       rf_we_o,
  output logic [1:0] wb_sel_o,
  output logic       illegal_o,
  output logic       bus_err_o,
  output logic [2:0] state_o
);

  // PC_ADDR is consumed by the datapath and the bus widths are pass-through;
  // a misaligned reset PC or degenerate widths simply build nothing extra.
  if ((PC_ADDR[1:0] != 2'b00) || (ADDR_WIDTH < 1) || (DATA_WIDTH < 1) ||
      (TIMEOUT_CYCLES < 1)) begin : g_cfg_unsupported
  end

  state_t state, state_nxt;
  logic   illegal_q;
  logic   to_expired;

`ifdef CTRL_BUS_TIMEOUT_EN
  logic in_wait;
  logic bus_err_q;

  assign in_wait = (state == S_FETCH) || (state == S_MEM);

  // An ack ends the access, so it also restarts the count for the next one.
  ctrl_bus_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_bus_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (!in_wait || mem_ack_i),
    .tick    (in_wait && !mem_ack_i),
    .expired (to_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          bus_err_q <= 1'b0;
    else if (to_expired) bus_err_q <= 1'b1;
  end

  assign bus_err_o = bus_err_q;
`else
  assign to_expired = 1'b0;
  assign bus_err_o  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       illegal_q <= 1'b0;
    else if (state == S_DECODE && !is_legal_op(opcode)) illegal_q <= 1'b1;
  end

  assign illegal_o = illegal_q;
  assign state_o   = state;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ack_i)       state_nxt = S_DECODE;
        else if (to_expired) state_nxt = S_TRAP;
      end
      S_DECODE: state_nxt = is_legal_op(opcode) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) state_nxt = S_MEM;
        else if (opcode == OP_BRANCH)                state_nxt = S_FETCH;
        else                                         state_nxt = S_WB;
      end
      S_MEM: begin
        if (mem_ack_i)       state_nxt = (opcode == OP_STORE) ? S_FETCH : S_WB;
        else if (to_expired) state_nxt = S_TRAP;
      end
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic; ir_we_o is the only ack-dependent (Mealy) strobe.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_src_o       = PC_SRC_PC4;
    pc_rst_o       = 1'b0;
    rf_we_o        = 1'b0;
    wb_sel_o       = WB_SEL_ALU;
    case (state)
      S_IDLE:  pc_rst_o = 1'b1;
      S_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ack_i;
      end
      S_EXEC: begin
        pc_we_o = 1'b1;
        if (opcode == OP_JAL)         pc_src_o = PC_SRC_REL;
        else if (opcode == OP_JALR)   pc_src_o = PC_SRC_JALR;
        else if (opcode == OP_BRANCH) pc_src_o = branch_cond_i ? PC_SRC_REL : PC_SRC_PC4;
      end
      S_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = (opcode == OP_STORE);
      end
      S_WB: begin
        rf_we_o = 1'b1;
        if (opcode == OP_LOAD)                          wb_sel_o = WB_SEL_MEM;
        else if (opcode == OP_JAL || opcode == OP_JALR) wb_sel_o = WB_SEL_PC4;
      end
      default: ;
    endcase
  end

endmodule
